ram8_arbiter: RTL
=================

RAM8_ARBITER -- requirements
Module: ram8_arbiter

Interface
REQ-001 Parameter: INIT_CLEAR, default 1, 1 = zero all 8 RAM words after every reset before serving requests; 0 = serve immediately.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a_req  input  1  port A transfer request; held high until granted.
REQ-005 a_we  input  1  port A write enable (1 = write, 0 = read); valid while a_req high.
REQ-006 a_addr  input  3  port A word address.
REQ-007 a_wdata  input  16  port A write data.
REQ-008 a_gnt  output  1  port A granted this cycle; transfer occurs in the cycle where a_req & a_gnt.
REQ-009 a_rvalid  output  1  one-cycle pulse: a_rdata holds the result of A's read granted in the previous cycle.
REQ-010 a_rdata  output  16  port A read data, registered.
REQ-011 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B, same directions, widths and meanings as REQ-004..REQ-010.
REQ-012 ram_in  output  16  write data to the 8-word RAM.
REQ-013 ram_address  output  3  RAM word address.
REQ-014 ram_load  output  1  RAM write strobe; RAM captures ram_in at ram_address on the next rising clk.
REQ-015 ram_out  input  16  RAM read data, combinational from ram_address.
REQ-016 busy  output  1  high while INIT clear sequence runs.

Function
REQ-017 Two states: INIT and RUN; reset enters INIT if INIT_CLEAR=1, else RUN.
REQ-018 INIT: 3-bit counter cnt from 0; each cycle ram_load=1, ram_address=cnt, ram_in=0; cnt increments; after the cycle with cnt=7, next state RUN (exactly 8 INIT cycles).
REQ-019 INIT: busy=1, a_gnt=b_gnt=0, rvalid low; requests ignored (remain pending).
REQ-020 RUN: busy=0; grant decision combinational from a_req, b_req and priority pointer ptr.
REQ-021 Only one requester: that port granted. Both: port named by ptr granted. None: no grant.
REQ-022 ptr resets to A; after any grant, ptr points to the non-granted port (round-robin); unchanged when no grant.
REQ-023 At most one gnt high per cycle.
REQ-024 Granted port drives ram_address=addr, ram_in=wdata, ram_load=we, all combinational.
REQ-025 No grant in RUN: ram_load=0, ram_address=0, ram_in=0.
REQ-026 Granted read: ram_out captured into that port's rdata at the edge ending the grant cycle; that port's rvalid high for exactly the following cycle.
REQ-027 rdata holds its value until that port's next granted read; writes never alter rdata or assert rvalid.
REQ-028 Latency: write visible in RAM 1 edge after grant; read data valid 1 cycle after grant.
REQ-029 Write at address X followed by a read of X in the next cycle (either port) returns the new data.
REQ-030 A single requester may be granted on consecutive cycles; full throughput 1 transfer/cycle.
REQ-031 Both requesting continuously: grants alternate strictly A, B, A, B ...
REQ-032 cnt wraps 7->0 only once per INIT; no other wrap-around state.

Reset
REQ-033 rst_n low, at any time including mid-INIT or mid-transfer: immediately gnt=0, rvalid=0, rdata=0, ram_load=0, ram_address=0, ram_in=0, busy=0, ptr=A, cnt=0.
REQ-034 On rst_n release: first clk edge begins INIT (busy=1 from that cycle) when INIT_CLEAR=1, else RUN.
REQ-035 A transfer interrupted by reset is lost; no rvalid issued for it.

Verification
REQ-036 Reset release, INIT_CLEAR=1, RAM preloaded with 16'hFFFF -> busy high 8 cycles, ram_load high addresses 0..7, then all words read 16'h0000.
REQ-037 A writes 16'h1234 to addr 5, next cycle B reads addr 5 -> b_rvalid one cycle later, b_rdata=16'h1234, a_rdata unchanged.
REQ-038 a_req and b_req held high 6 cycles (reads of addr 1 and 2) -> grants A,B,A,B,A,B; one rvalid per grant with correct data.
REQ-039 Only A requests 4 consecutive writes to addr 0..3 -> a_gnt high 4 cycles, b_gnt never high, data stored correctly.
REQ-040 rst_n pulsed low during INIT cycle 4 and during an A read grant -> outputs zero immediately, no a_rvalid, INIT restarts from address 0 for full 8 cycles.
REQ-041 INIT_CLEAR=0, A read request at first cycle after reset -> a_gnt high that cycle, busy never high.

Source files
------------

// File: rtl/ram8_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram8_arbiter_if
//  Description : Bundle of the two requester ports (A and B), the RAM-side
//                signals and the busy flag of ram8_arbiter.
//                slave  : arbiter view (requests in, grants/read data out,
//                         drives the RAM, receives ram_out)
//                master : environment view (requesters plus the RAM model)
//  Ports       : a_req/a_we/a_addr/a_wdata   -> port A request
//                a_gnt/a_rvalid/a_rdata      <- port A response
//                b_*                         same meaning for port B
//                ram_in/ram_address/ram_load <- RAM write side
//                ram_out                     -> RAM read data
//                busy                        <- clear sequence active
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram8_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [2:0]  a_addr;
    logic [15:0] a_wdata;
    logic        a_gnt;
    logic        a_rvalid;
    logic [15:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [2:0]  b_addr;
    logic [15:0] b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic [15:0] b_rdata;

    logic [15:0] ram_in;
    logic [2:0]  ram_address;
    logic        ram_load;
    logic [15:0] ram_out;

    logic        busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_out,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_in, ram_address, ram_load,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_out,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_in, ram_address, ram_load,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/ram8_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram8_arbiter
//  Description : Two-port round-robin arbiter in front of an 8 x 16-bit RAM
//                with combinational read. After reset it optionally zeroes
//                all eight words (INIT_CLEAR=1) before serving requests.
//                One transfer per cycle; read data is registered per port.
//  Ports       : clk    - single clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - ram8_arbiter_if.slave (requester ports A/B,
//                         RAM interface, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module ram8_arbiter #(
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    ram8_arbiter_if.slave bus
);

    // IDLE is the state held while rst_n is low; it makes every output zero
    // and lets the first edge after release choose between INIT and RUN.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_INIT  = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;

    localparam logic       c_PTR_A    = 1'b0;
    localparam logic       c_PTR_B    = 1'b1;
    localparam logic [2:0] c_CNT_LAST = 3'd7;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_cnt;
    logic        r_ptr;

    logic        r_a_rvalid;
    logic        r_b_rvalid;
    logic [15:0] r_a_rdata;
    logic [15:0] r_b_rdata;

    logic        w_gnt_a;
    logic        w_gnt_b;
    logic        w_busy;
    logic        w_ram_load;
    logic [2:0]  w_ram_address;
    logic [15:0] w_ram_in;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: w_state_nxt = INIT_CLEAR ? c_ST_INIT : c_ST_RUN;
            c_ST_INIT: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN:  w_state_nxt = c_ST_RUN;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: grant decision and RAM-side multiplexing
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_a       = 1'b0;
        w_gnt_b       = 1'b0;
        w_busy        = 1'b0;
        w_ram_load    = 1'b0;
        w_ram_address = 3'd0;
        w_ram_in      = 16'd0;
        case (r_state)
            c_ST_INIT: begin
                w_busy        = 1'b1;
                w_ram_load    = 1'b1;
                w_ram_address = r_cnt;
            end
            c_ST_RUN: begin
                // A lone requester always wins; on contention ptr decides.
                w_gnt_a = bus.a_req & (~bus.b_req | (r_ptr == c_PTR_A));
                w_gnt_b = bus.b_req & (~bus.a_req | (r_ptr == c_PTR_B));
                if (w_gnt_a) begin
                    w_ram_address = bus.a_addr;
                    w_ram_in      = bus.a_wdata;
                    w_ram_load    = bus.a_we;
                end else if (w_gnt_b) begin
                    w_ram_address = bus.b_addr;
                    w_ram_in      = bus.b_wdata;
                    w_ram_load    = bus.b_we;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Clear counter, round-robin pointer and per-port read registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 3'd0;
            r_ptr      <= c_PTR_A;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= 16'd0;
            r_b_rdata  <= 16'd0;
        end else begin
            // Counter only advances in INIT; it leaves INIT exactly as it
            // wraps 7->0, so it is back at zero for any later clear.
            r_cnt <= (r_state == c_ST_INIT) ? r_cnt + 3'd1 : 3'd0;

            if (w_gnt_a) begin
                r_ptr <= c_PTR_B;
            end else if (w_gnt_b) begin
                r_ptr <= c_PTR_A;
            end

            r_a_rvalid <= w_gnt_a & ~bus.a_we;
            r_b_rvalid <= w_gnt_b & ~bus.b_we;

            if (w_gnt_a & ~bus.a_we) begin
                r_a_rdata <= bus.ram_out;
            end
            if (w_gnt_b & ~bus.b_we) begin
                r_b_rdata <= bus.ram_out;
            end
        end
    end

    assign bus.a_gnt       = w_gnt_a;
    assign bus.b_gnt       = w_gnt_b;
    assign bus.a_rvalid    = r_a_rvalid;
    assign bus.b_rvalid    = r_b_rvalid;
    assign bus.a_rdata     = r_a_rdata;
    assign bus.b_rdata     = r_b_rdata;
    assign bus.ram_in      = w_ram_in;
    assign bus.ram_address = w_ram_address;
    assign bus.ram_load    = w_ram_load;
    assign bus.busy        = w_busy;

endmodule
`default_nettype wire
